// File: rtl/minisys_pkg.sv
// Shared types and constants for the EX/MEM pipeline register and store alignment.
// Optional feature macro used by this slice: MINISYS_MISALIGN_EXC_EN.
package minisys_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {StNone, StByte, StHalf, StWord} st_size_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        memwrite;
    logic              op_lb;
    logic              op_lbu;
    logic              op_lh;
    logic              op_lhu;
    logic              op_lw;
    logic              regwrite;
    logic              memtoreg;
    logic [4:0]        write_reg;
    logic              exc_adel;
    logic              exc_ades;
    logic [DATA_W-1:0] badvaddr;
  } mem_stage_t;

  // Store strobes should be one-hot; resolve overlaps as sw > sh > sb.
  function automatic st_size_t st_size(input logic sb, input logic sh, input logic sw);
    if (sw) return StWord;
    if (sh) return StHalf;
    if (sb) return StByte;
    return StNone;
  endfunction

endpackage

// File: rtl/minisys_store_align.sv
// Combinational store alignment: byte-write mask, lane-replicated data and misalign flag.
// The misalign flag is only produced when MINISYS_MISALIGN_EXC_EN is defined.
module minisys_store_align
  import minisys_pkg::*;
(
  input  st_size_t          size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              misalign_o
);

  always_comb begin
    be_o    = BE_NONE;
    wdata_o = wdata_i;
    unique case (size_i)
      StByte: begin
        wdata_o = {4{wdata_i[7:0]}};
        unique case (addr_lo_i)
          2'd0: be_o = BE_B0;
          2'd1: be_o = BE_B1;
          2'd2: be_o = BE_B2;
          2'd3: be_o = BE_B3;
          default: be_o = BE_NONE;
        endcase
      end
      StHalf: begin
        wdata_o = {2{wdata_i[15:0]}};
        be_o    = addr_lo_i[1] ? BE_HHI : BE_HLO;
      end
      StWord: be_o = BE_WORD;
      default: be_o = BE_NONE;
    endcase
  end

`ifdef MINISYS_MISALIGN_EXC_EN
  assign misalign_o = ((size_i == StHalf) && addr_lo_i[0]) ||
                      ((size_i == StWord) && (addr_lo_i != 2'b00));
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/minisys_ex_mem.sv
// EX/MEM pipeline register with reset > flush > stall > capture priority.
// Define MINISYS_MISALIGN_EXC_EN to raise address-error exceptions on misaligned accesses.
module minisys_ex_mem
  import minisys_pkg::*;
#(
  parameter int unsigned DATA_W = 32  // only 32 is supported
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              stallM,
  input  logic              flushM,
  input  logic              validE,
  input  logic [DATA_W-1:0] alu_outE,
  input  logic [DATA_W-1:0] write_dataE,
  input  logic              op_sbE,
  input  logic              op_shE,
  input  logic              op_swE,
  input  logic              op_lbE,
  input  logic              op_lbuE,
  input  logic              op_lhE,
  input  logic              op_lhuE,
  input  logic              op_lwE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [4:0]        write_regE,
  output logic              validM,
  output logic [DATA_W-1:0] alu_outM,
  output logic [DATA_W-1:0] write_dataM,
  output logic [3:0]        memwriteM,
  output logic              op_lbM,
  output logic              op_lbuM,
  output logic              op_lhM,
  output logic              op_lhuM,
  output logic              op_lwM,
  output logic              regwriteM,
  output logic              memtoregM,
  output logic [4:0]        write_regM,
  output logic              exc_adelM,
  output logic              exc_adesM,
  output logic [DATA_W-1:0] badvaddrM
);

  st_size_t          size_e;
  logic [3:0]        be_e;
  logic [DATA_W-1:0] wdata_e;
  logic              st_mis;
  logic              ld_mis;
  logic              ld_en;
  logic              err;
  mem_stage_t        cap;
  mem_stage_t        stage_d;
  mem_stage_t        stage_q;

  assign size_e = validE ? st_size(op_sbE, op_shE, op_swE) : StNone;
  // A store in the slot clears any load strobes.
  assign ld_en  = validE && (size_e == StNone);

  minisys_store_align u_store_align (
    .size_i     (size_e),
    .addr_lo_i  (alu_outE[1:0]),
    .wdata_i    (write_dataE),
    .be_o       (be_e),
    .wdata_o    (wdata_e),
    .misalign_o (st_mis)
  );

`ifdef MINISYS_MISALIGN_EXC_EN
  assign ld_mis = ld_en && (((op_lhE || op_lhuE) && alu_outE[0]) ||
                            (op_lwE && (alu_outE[1:0] != 2'b00)));
`else
  assign ld_mis = 1'b0;
`endif

  assign err = ld_mis || st_mis;

  always_comb begin
    cap            = '0;
    cap.valid      = validE;
    cap.alu_out    = alu_outE;
    cap.write_data = wdata_e;
    cap.memwrite   = err ? BE_NONE : be_e;
    cap.op_lb      = ld_en && op_lbE && !err;
    cap.op_lbu     = ld_en && op_lbuE && !err;
    cap.op_lh      = ld_en && op_lhE && !err;
    cap.op_lhu     = ld_en && op_lhuE && !err;
    cap.op_lw      = ld_en && op_lwE && !err;
    cap.regwrite   = validE && regwriteE && !err;
    cap.memtoreg   = validE && memtoregE;
    cap.write_reg  = write_regE;
    cap.exc_adel   = ld_mis;
    cap.exc_ades   = st_mis;
    cap.badvaddr   = err ? alu_outE : '0;
  end

  always_comb begin
    stage_d = cap;
    if (flushM) begin
      stage_d = '0;
    end else if (stallM) begin
      stage_d = stage_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign validM      = stage_q.valid;
  assign alu_outM    = stage_q.alu_out;
  assign write_dataM = stage_q.write_data;
  assign memwriteM   = stage_q.memwrite;
  assign op_lbM      = stage_q.op_lb;
  assign op_lbuM     = stage_q.op_lbu;
  assign op_lhM      = stage_q.op_lh;
  assign op_lhuM     = stage_q.op_lhu;
  assign op_lwM      = stage_q.op_lw;
  assign regwriteM   = stage_q.regwrite;
  assign memtoregM   = stage_q.memtoreg;
  assign write_regM  = stage_q.write_reg;
  assign exc_adelM   = stage_q.exc_adel;
  assign exc_adesM   = stage_q.exc_ades;
  assign badvaddrM   = stage_q.badvaddr;

endmodule

// File: tb/tb_minisys_ex_mem.sv
// Scoreboard bench for minisys_ex_mem: reference model predicts each registered stage.
module tb_minisys_ex_mem;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stallM, flushM, validE;
  logic [31:0] alu_outE, write_dataE;
  logic        op_sbE, op_shE, op_swE;
  logic        op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE;
  logic        regwriteE, memtoregE;
  logic [4:0]  write_regE;
  logic        validM;
  logic [31:0] alu_outM, write_dataM;
  logic [3:0]  memwriteM;
  logic        op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM;
  logic        regwriteM, memtoregM;
  logic [4:0]  write_regM;
  logic        exc_adelM, exc_adesM;
  logic [31:0] badvaddrM;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [4:0]  loads;  // {lb, lbu, lh, lhu, lw}
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  wreg;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
  } out_t;

  out_t exp_q[$];
  out_t model;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  minisys_ex_mem #(.DATA_W(32)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .stallM      (stallM),
    .flushM      (flushM),
    .validE      (validE),
    .alu_outE    (alu_outE),
    .write_dataE (write_dataE),
    .op_sbE      (op_sbE),
    .op_shE      (op_shE),
    .op_swE      (op_swE),
    .op_lbE      (op_lbE),
    .op_lbuE     (op_lbuE),
    .op_lhE      (op_lhE),
    .op_lhuE     (op_lhuE),
    .op_lwE      (op_lwE),
    .regwriteE   (regwriteE),
    .memtoregE   (memtoregE),
    .write_regE  (write_regE),
    .validM      (validM),
    .alu_outM    (alu_outM),
    .write_dataM (write_dataM),
    .memwriteM   (memwriteM),
    .op_lbM      (op_lbM),
    .op_lbuM     (op_lbuM),
    .op_lhM      (op_lhM),
    .op_lhuM     (op_lhuM),
    .op_lwM      (op_lwM),
    .regwriteM   (regwriteM),
    .memtoregM   (memtoregM),
    .write_regM  (write_regM),
    .exc_adelM   (exc_adelM),
    .exc_adesM   (exc_adesM),
    .badvaddrM   (badvaddrM)
  );

  function automatic out_t actual();
    out_t o;
    o.valid    = validM;
    o.alu      = alu_outM;
    o.wdata    = write_dataM;
    o.mask     = memwriteM;
    o.loads    = {op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM};
    o.regwrite = regwriteM;
    o.memtoreg = memtoregM;
    o.wreg     = write_regM;
    o.adel     = exc_adelM;
    o.ades     = exc_adesM;
    o.badv     = badvaddrM;
    return o;
  endfunction

  // Reference: what the M stage should hold after capturing the current EX inputs.
  function automatic out_t predict();
    out_t o;
    int   size;  // bytes stored: 0, 1, 2 or 4
    int   a;
    bit   err;
    a    = int'(alu_outE[1:0]);
    size = 0;
    if (validE) size = op_swE ? 4 : op_shE ? 2 : op_sbE ? 1 : 0;
    o = '0;
    o.valid    = validE;
    o.alu      = alu_outE;
    o.wreg     = write_regE;
    o.regwrite = validE && regwriteE;
    o.memtoreg = validE && memtoregE;
    o.wdata    = write_dataE;
    if (validE && size == 0) o.loads = {op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE};
    case (size)
      1: begin o.mask = 4'(1 << a);              o.wdata = 32'(write_dataE[7:0]) * 32'h01010101; end
      2: begin o.mask = 4'(3 << ((a / 2) * 2));  o.wdata = 32'(write_dataE[15:0]) * 32'h00010001; end
      4: o.mask = 4'hF;
      default: o.mask = 4'h0;
    endcase
    err = 1'b0;
`ifdef MINISYS_MISALIGN_EXC_EN
    o.adel = ((o.loads[2] || o.loads[1]) && (a % 2 != 0)) || (o.loads[0] && a != 0);
    o.ades = (size == 2 && a % 2 != 0) || (size == 4 && a != 0);
    err    = o.adel || o.ades;
    if (err) begin
      o.badv     = alu_outE;
      o.mask     = 4'h0;
      o.loads    = 5'b0;
      o.regwrite = 1'b0;
    end
`endif
    return o;
  endfunction

  task automatic push_expected();
    if (flushM) model = '0;
    else if (!stallM) model = predict();
    exp_q.push_back(model);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic chk_all(input string name, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every stage update is compared against the oldest prediction.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all("scoreboard", actual(), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_ex();
    stallM = 0; flushM = 0; validE = 0; alu_outE = '0; write_dataE = '0;
    op_sbE = 0; op_shE = 0; op_swE = 0;
    op_lbE = 0; op_lbuE = 0; op_lhE = 0; op_lhuE = 0; op_lwE = 0;
    regwriteE = 0; memtoregE = 0; write_regE = '0;
  endtask

  task automatic set_store(input int kind, input logic [31:0] addr, input logic [31:0] data);
    clear_ex();
    validE = 1; alu_outE = addr; write_dataE = data;
    op_sbE = (kind == 1); op_shE = (kind == 2); op_swE = (kind == 4);
  endtask

  task automatic set_lw(input logic [31:0] addr, input logic [4:0] rd);
    clear_ex();
    validE = 1; alu_outE = addr; op_lwE = 1; regwriteE = 1; memtoregE = 1; write_regE = rd;
  endtask

  task automatic rand_ex();
    int r;
    validE      = ($urandom_range(0, 7) != 0);
    alu_outE    = $urandom;
    write_dataE = $urandom;
    r = $urandom_range(0, 9);
    op_sbE = (r == 0); op_shE = (r == 1); op_swE = (r == 2);
    if (r == 3) {op_sbE, op_shE, op_swE} = 3'($urandom_range(1, 7));
    r = $urandom_range(0, 7);
    {op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE} = (r < 5) ? 5'(1 << r) : 5'b0;
    if (r == 7) {op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE} = 5'($urandom);
    regwriteE  = $urandom_range(0, 1) != 0;
    memtoregE  = $urandom_range(0, 1) != 0;
    write_regE = 5'($urandom);
    stallM     = ($urandom_range(0, 4) == 0);
    flushM     = ($urandom_range(0, 9) == 0);
  endtask

  // Assert reset in the middle of a cycle, after the last queued edge has been checked.
  task automatic async_reset();
    @(posedge clk);
    #3;
    clrn = 0;
    #1;
    chk_all("reset_all_zero", actual(), '0);
    chk("reset_memwrite", 32'(memwriteM), 32'h0);
    model = '0;
  endtask

  initial begin
    clrn  = 0;
    model = '0;
    clear_ex();
    @(negedge clk);
    chk_all("initial_reset", actual(), '0);

    // Capture a word store, then reset mid-cycle while op_swE is still presented.
    clrn = 1;
    set_store(4, 32'h0000_0100, 32'hCAFE_F00D);
    push_expected();
    @(negedge clk);
    push_expected();
    async_reset();

    // First edge after release captures EX: byte store.
    @(negedge clk);
    clrn = 1;
    set_store(1, 32'h0000_1002, 32'h1234_56AB);
    push_expected();
    @(posedge clk); #2;
    chk("sb_mask", 32'(memwriteM), 32'h4);
    chk("sb_data", write_dataM, 32'hABAB_ABAB);
    chk("sb_addr", alu_outM, 32'h0000_1002);

    @(negedge clk);
    set_store(2, 32'h0000_2002, 32'h0000_BEEF);
    push_expected();
    @(posedge clk); #2;
    chk("sh_mask", 32'(memwriteM), 32'hC);
    chk("sh_data", write_dataM, 32'hBEEF_BEEF);

    @(negedge clk);
    set_store(4, 32'h0000_3000, 32'h1357_9BDF);
    push_expected();
    @(posedge clk); #2;
    chk("sw_mask", 32'(memwriteM), 32'hF);
    chk("sw_data", write_dataM, 32'h1357_9BDF);

    // Stall holds a captured lw while EX changes; flush overrides stall.
    @(negedge clk);
    set_lw(32'h0000_4000, 5'd5);
    push_expected();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_ex();
      stallM = 1; flushM = 0;
      push_expected();
      @(posedge clk); #2;
      chk("stall_op_lw", 32'(op_lwM), 32'h1);
      chk("stall_wreg", 32'(write_regM), 32'd5);
    end
    @(negedge clk);
    rand_ex();
    stallM = 1; flushM = 1;
    push_expected();
    @(posedge clk); #2;
    chk_all("flush_bubble", actual(), '0);

    // Reset during a stall discards the held instruction.
    @(negedge clk);
    set_lw(32'h0000_5000, 5'd9);
    push_expected();
    @(negedge clk);
    stallM = 1;
    push_expected();
    async_reset();
    @(negedge clk);
    clrn = 1;
    set_store(1, 32'h0000_0001, 32'h0000_0077);
    push_expected();
    @(posedge clk); #2;
    chk("post_reset_capture_mask", 32'(memwriteM), 32'h2);

    // Misaligned lw and sw/sh.
    @(negedge clk);
    set_lw(32'h0000_0003, 5'd7);
    push_expected();
    @(posedge clk); #2;
`ifdef MINISYS_MISALIGN_EXC_EN
    chk("mis_lw_adel", 32'(exc_adelM), 32'h1);
    chk("mis_lw_badv", badvaddrM, 32'h3);
    chk("mis_lw_op", 32'(op_lwM), 32'h0);
    chk("mis_lw_regwrite", 32'(regwriteM), 32'h0);
    @(negedge clk);
    set_store(2, 32'h0000_0005, 32'h0000_1234);
    push_expected();
    @(posedge clk); #2;
    chk("mis_sh_ades", 32'(exc_adesM), 32'h1);
    chk("mis_sh_mask", 32'(memwriteM), 32'h0);
`else
    chk("mis_lw_op", 32'(op_lwM), 32'h1);
    chk("mis_lw_adel", 32'(exc_adelM), 32'h0);
    chk("mis_lw_badv", badvaddrM, 32'h0);
    @(negedge clk);
    set_store(4, 32'h0000_0002, 32'h0000_1234);
    push_expected();
    @(posedge clk); #2;
    chk("mis_sw_mask", 32'(memwriteM), 32'hF);
    chk("mis_sw_ades", 32'(exc_adesM), 32'h0);
`endif

    // Store with load strobes and overlapping store strobes.
    @(negedge clk);
    set_store(1, 32'h0000_0003, 32'h0000_00C3);
    op_lwE = 1; op_shE = 1;
    push_expected();
    @(posedge clk); #2;
    chk("store_clears_load", 32'(op_lwM), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_ex();
      push_expected();
    end

    @(negedge clk);
    clear_ex();
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
